// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register: valid/ready handshake, 2-entry skid buffer, Tnew countdown, exception tag.
// Optional PIPE_STAGE_STATS_EN adds a saturating 32-bit stall_cnt output.
module pipe_stage_skid #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned TNEW_W   = 2,
   parameter int unsigned TNEW_DEC = 1,
   parameter int unsigned CODE_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [TNEW_W-1:0] in_tnew,
   input  logic              in_exc,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TNEW_W-1:0] out_tnew,
   output logic              out_exc,
   output logic [CODE_W-1:0] out_code
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t            state;
   logic [DATA_W-1:0] skid_data;
   logic [TNEW_W-1:0] skid_tnew;
   logic              skid_exc;
   logic [CODE_W-1:0] skid_code;

   logic              take;
   logic              give;
   logic [TNEW_W-1:0] cap_tnew;
   logic [CODE_W-1:0] cap_code;

   assign in_ready = (state != FULL) && !reset;
   assign take     = in_valid && in_ready;
   assign give     = out_valid && out_ready;

   // Tnew is decremented once on entry and clamped at zero; entries keep it afterwards.
   always_comb begin
      cap_tnew = '0;
      if (32'(in_tnew) >= TNEW_DEC)
         cap_tnew = in_tnew - TNEW_W'(TNEW_DEC);
      cap_code = in_exc ? in_code : '0;
   end

   // Main entry registers are zeroed whenever the stage empties so bubbles present as NOPs.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tnew  <= '0;
         out_exc   <= 1'b0;
         out_code  <= '0;
         skid_data <= '0;
         skid_tnew <= '0;
         skid_exc  <= 1'b0;
         skid_code <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (take) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_tnew  <= cap_tnew;
                  out_exc   <= in_exc;
                  out_code  <= cap_code;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (take && give) begin
                  out_data <= in_data;
                  out_tnew <= cap_tnew;
                  out_exc  <= in_exc;
                  out_code <= cap_code;
               end else if (take) begin
                  skid_data <= in_data;
                  skid_tnew <= cap_tnew;
                  skid_exc  <= in_exc;
                  skid_code <= cap_code;
                  state     <= FULL;
               end else if (give) begin
                  out_valid <= 1'b0;
                  out_data  <= '0;
                  out_tnew  <= '0;
                  out_exc   <= 1'b0;
                  out_code  <= '0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (give) begin
                  out_data  <= skid_data;
                  out_tnew  <= skid_tnew;
                  out_exc   <= skid_exc;
                  out_code  <= skid_code;
                  skid_data <= '0;
                  skid_tnew <= '0;
                  skid_exc  <= 1'b0;
                  skid_code <= '0;
                  state     <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed literal checks plus randomized traffic against a queue model.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic [1:0]  in_tnew = '0;
   logic        in_exc = 1'b0;
   logic [4:0]  in_code = '0;

   logic        in_ready, out_valid, out_exc;
   logic [31:0] out_data;
   logic [1:0]  out_tnew;
   logic [4:0]  out_code;

   logic        in_ready2, out_valid2, out_exc2;
   logic [31:0] out_data2;
   logic [1:0]  out_tnew2;
   logic [4:0]  out_code2;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cnt, stall_cnt2;
`endif

   pipe_stage_skid #(.DATA_W(32), .TNEW_W(2), .TNEW_DEC(1), .CODE_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_tnew(in_tnew), .in_exc(in_exc), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tnew(out_tnew), .out_exc(out_exc), .out_code(out_code)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   pipe_stage_skid #(.DATA_W(32), .TNEW_W(2), .TNEW_DEC(0), .CODE_W(5)) dut_nodec (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .in_tnew(in_tnew), .in_exc(in_exc), .in_code(in_code),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_tnew(out_tnew2), .out_exc(out_exc2), .out_code(out_code2)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cnt(stall_cnt2)
`endif
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned passed = 0;
   bit          started = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: the stage is a FIFO of at most two raw upstream entries.
   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  t;
      logic        e;
      logic [4:0]  c;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_stall = '0;

   function automatic logic [40:0] expect_out(input int unsigned dec);
      ent_t        x;
      int unsigned t;
      if (q.size() == 0) return '0;
      x = q[0];
      t = (int'(x.t) >= int'(dec)) ? int'(x.t) - dec : 0;
      return {1'b1, x.d, 2'(t), x.e, x.e ? x.c : 5'd0};
   endfunction

   always @(posedge clk) begin
      bit   acc;
      bit   dlv;
      ent_t n;
      acc = in_valid && (q.size() < 2) && !reset;
      dlv = (q.size() > 0) && out_ready;
      if (reset) m_stall = '0;
      else if ((q.size() > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (reset || flush) q.delete();
      else begin
         if (dlv) void'(q.pop_front());
         if (acc) begin
            n.d = in_data; n.t = in_tnew; n.e = in_exc; n.c = in_code;
            q.push_back(n);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("out", 64'({out_valid, out_data, out_tnew, out_exc, out_code}), 64'(expect_out(1)));
         chk("out_nodec", 64'({out_valid2, out_data2, out_tnew2, out_exc2, out_code2}), 64'(expect_out(0)));
         chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !reset));
`ifdef PIPE_STAGE_STATS_EN
         chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] d, input logic [1:0] t, input logic e, input logic [4:0] c);
      in_valid = 1'b1; in_data = d; in_tnew = t; in_exc = e; in_code = c;
   endtask

   initial begin
      // Reset held two cycles with in_valid asserted.
      put(32'hAA, 2'd3, 1'b1, 5'h1F);
      tick();
      started = 1'b1;
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      // Streaming 1..8 with no back-pressure.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         put(32'(i), 2'd0, 1'b0, 5'd0);
         tick();
         chk("stream_data", 64'(out_data), 64'(i));
         chk("stream_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 64'(out_valid), 64'd0);

      // Back-pressure: A then B fill the stage.
      out_ready = 1'b0;
      put(32'hA, 2'd0, 1'b0, 5'd0);
      tick();
      chk("bp_a", 64'(out_data), 64'hA);
      put(32'hB, 2'd0, 1'b0, 5'd0);
      tick();
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_a", 64'(out_data), 64'hA);
      in_valid = 1'b0;
      tick();
      tick();
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_3", 64'(stall_cnt), 64'd3);
`endif
      out_ready = 1'b1;
      tick();
      chk("bp_b", 64'(out_data), 64'hB);
      tick();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Tnew saturation and pass-through.
      put(32'h1, 2'd2, 1'b0, 5'd0);
      tick();
      chk("tnew_2", 64'(out_tnew), 64'd1);
      put(32'h2, 2'd0, 1'b0, 5'd0);
      tick();
      chk("tnew_0", 64'(out_tnew), 64'd0);
      put(32'h3, 2'd3, 1'b0, 5'd0);
      tick();
      chk("tnew_nodec_3", 64'(out_tnew2), 64'd3);
      in_valid = 1'b0;
      tick();

      // Flush while FULL with a new entry offered.
      out_ready = 1'b0;
      put(32'hC, 2'd1, 1'b0, 5'd0);
      tick();
      put(32'hD, 2'd1, 1'b0, 5'd0);
      tick();
      put(32'hE, 2'd1, 1'b1, 5'd3);
      flush = 1'b1;
      tick();
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_outs", 64'({out_data, out_tnew, out_exc, out_code}), 64'd0);
      chk("flush_ready", 64'(in_ready), 64'd1);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("flush_lost", 64'(out_valid), 64'd0);

      // Exception code masking.
      put(32'h10, 2'd0, 1'b0, 5'h0C);
      tick();
      chk("exc0_code", 64'({out_exc, out_code}), 64'd0);
      put(32'h11, 2'd0, 1'b1, 5'h04);
      tick();
      chk("exc1_code", 64'({out_exc, out_code}), 64'({1'b1, 5'h04}));
      in_valid = 1'b0;
      tick();

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         in_tnew   = 2'($urandom);
         in_exc    = ($urandom_range(0, 3) == 0);
         in_code   = 5'($urandom);
         flush     = ($urandom_range(0, 29) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
